mem_stage_hs: RTL and testbench

Parametrised memory stage plus M/W pipeline register for the five-stage RISC-V core. Performs byte/half/word loads and stores through a valid/ack handshake to a variable-latency data memory, sign- or zero-extends load data, and stalls upstream while an access is outstanding. It sits between the execute-stage register and the writeback mux, replacing the fixed single-cycle memory stage.

---
 rtl/core_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 92 +++++++++
 rtl/mem_stage_hs.sv | 129 ++++++++++++
 tb/tb_mem_stage_hs.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: load/store funct3 encodings, access sizes and the memory-stage FSM states.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Doubleword accesses only exist on RV64; elsewhere they degrade to word width.
    function automatic logic [1:0] eff_size(input logic [2:0] f3, input int unsigned xlen);
        if (f3[1:0] == SZ_D && xlen != 64) begin
            return SZ_W;
        end
        return f3[1:0];
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replication and byte enables, load extract and extension.
module mem_lane_align
    import core_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  offset,
    input  logic              is_store,
    input  logic [XLEN-1:0]   wdata_in,
    input  logic [XLEN-1:0]   rdata_in,
    output logic [XLEN-1:0]   wdata_out,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   rdata_out,
    output logic              misaligned
);

    logic [1:0]       size;
    logic [OFF_W-1:0] align_off;
    logic [OFF_W+2:0] shamt;
    logic [63:0]      shifted;
    logic [63:0]      w64;
    logic [63:0]      r64;
    logic [7:0]       be64;
    logic             sext;

    assign size  = eff_size(funct3, XLEN);
    assign sext  = ~funct3[2];
    assign shamt = {align_off, 3'b000};

    always_comb begin
        align_off  = offset;
        misaligned = 1'b0;
        unique case (size)
            SZ_B: begin
                align_off  = offset;
                misaligned = 1'b0;
            end
            SZ_H: begin
                align_off  = offset & ~OFF_W'(1);
                misaligned = offset[0];
            end
            SZ_W: begin
                align_off  = offset & ~OFF_W'(3);
                misaligned = |offset[1:0];
            end
            default: begin
                align_off  = '0;
                misaligned = |offset;
            end
        endcase
    end

    // Work in 64 bits so one body serves both XLEN settings.
    always_comb begin
        shifted = 64'(rdata_in >> shamt);
        w64     = 64'(wdata_in);
        be64    = 8'hFF;
        r64     = shifted;
        unique case (size)
            SZ_B: begin
                w64  = {8{wdata_in[7:0]}};
                be64 = 8'h01 << align_off;
                r64  = {{56{sext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                w64  = {4{wdata_in[15:0]}};
                be64 = 8'h03 << align_off;
                r64  = {{48{sext & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                w64  = {2{wdata_in[31:0]}};
                be64 = 8'h0F << align_off;
                r64  = {{32{sext & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                w64  = 64'(wdata_in);
                be64 = 8'hFF;
                r64  = shifted;
            end
        endcase
        if (!is_store) begin
            be64 = 8'hFF;
        end
    end

    assign wdata_out = w64[XLEN-1:0];
    assign be        = be64[XLEN/8-1:0];
    assign rdata_out = r64[XLEN-1:0];

endmodule

// File: rtl/mem_stage_hs.sv
// Memory stage with valid/ack data-memory handshake and the M/W pipeline register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses trap instead of being truncated.
module mem_stage_hs
    import core_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_m,
    input  logic               regwrite_m,
    input  logic               memread_m,
    input  logic               memwrite_m,
    input  logic               resultsrc_m,
    input  logic [2:0]         funct3_m,
    input  logic [RADDR_W-1:0] rd_m,
    input  logic [XLEN-1:0]    pcplus4_m,
    input  logic [XLEN-1:0]    alu_result_m,
    input  logic [XLEN-1:0]    writedata_m,
    input  logic               flush_w,
    output logic               busy_m,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [XLEN-1:0]    dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic [XLEN/8-1:0]  dmem_be,
    input  logic               dmem_ack,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               regwrite_w,
    output logic               resultsrc_w,
    output logic [RADDR_W-1:0] rd_w,
    output logic [XLEN-1:0]    pcplus4_w,
    output logic [XLEN-1:0]    alu_result_w,
    output logic [XLEN-1:0]    readdata_w,
    output logic               trap_w
);

    localparam int unsigned OFF_W = $clog2(XLEN / 8);
    localparam logic [0:0]  IDLE  = MEM_IDLE;
    localparam logic [0:0]  WAIT  = MEM_WAIT;

    logic [0:0]      state_q, state_d;
    logic            mem_op;
    logic            misaligned;
    logic            access_ok;
    logic            trap;
    logic            complete;
    logic [XLEN-1:0] lane_rdata;

    assign mem_op = valid_m & (memread_m | memwrite_m);

`ifdef MEM_MISALIGN_TRAP_EN
    assign access_ok = ~misaligned;
    assign trap      = mem_op & misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign access_ok         = 1'b1;
    assign trap              = 1'b0;
`endif

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_lane (
        .funct3     (funct3_m),
        .offset     (alu_result_m[OFF_W-1:0]),
        .is_store   (memwrite_m),
        .wdata_in   (writedata_m),
        .rdata_in   (dmem_rdata),
        .wdata_out  (dmem_wdata),
        .be         (dmem_be),
        .rdata_out  (lane_rdata),
        .misaligned (misaligned)
    );

    // Request drops combinationally with reset so an abandoned access never lingers.
    assign dmem_req  = ~rst & ((state_q == WAIT) | (mem_op & access_ok));
    assign dmem_we   = dmem_req & memwrite_m;
    assign dmem_addr = {alu_result_m[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign busy_m    = dmem_req & ~dmem_ack;
    assign complete  = valid_m & ~busy_m;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = busy_m ? WAIT : IDLE;
            WAIT:    state_d = dmem_ack ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_w   <= 1'b0;
            resultsrc_w  <= 1'b0;
            rd_w         <= '0;
            pcplus4_w    <= '0;
            alu_result_w <= '0;
            readdata_w   <= '0;
            trap_w       <= 1'b0;
        end else if (flush_w || !complete) begin
            regwrite_w   <= 1'b0;
            resultsrc_w  <= 1'b0;
            rd_w         <= '0;
            pcplus4_w    <= '0;
            alu_result_w <= '0;
            readdata_w   <= '0;
            trap_w       <= 1'b0;
        end else begin
            regwrite_w   <= regwrite_m & ~trap;
            resultsrc_w  <= resultsrc_m;
            rd_w         <= rd_m;
            pcplus4_w    <= pcplus4_m;
            alu_result_w <= alu_result_m;
            readdata_w   <= (memread_m & dmem_ack) ? lane_rdata : '0;
            trap_w       <= trap;
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed, table-driven bench for mem_stage_hs (XLEN=32) plus hand sequences for reset and flush.
module tb_mem_stage_hs;
    import core_pkg::*;

    logic        clk, rst;
    logic        valid_m, regwrite_m, memread_m, memwrite_m, resultsrc_m;
    logic [2:0]  funct3_m;
    logic [4:0]  rd_m;
    logic [31:0] pcplus4_m, alu_result_m, writedata_m;
    logic        flush_w, busy_m, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        regwrite_w, resultsrc_w, trap_w;
    logic [4:0]  rd_w;
    logic [31:0] pcplus4_w, alu_result_w, readdata_w;

    logic [2:0]  la_f3;
    logic [1:0]  la_off;
    logic        la_st, la_mis;
    logic [31:0] la_wd, la_rd, la_wo, la_ro;
    logic [3:0]  la_be;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    logic [31:0] wr_addr, wr_data;

    mem_stage_hs #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .valid_m(valid_m), .regwrite_m(regwrite_m),
        .memread_m(memread_m), .memwrite_m(memwrite_m), .resultsrc_m(resultsrc_m),
        .funct3_m(funct3_m), .rd_m(rd_m), .pcplus4_m(pcplus4_m),
        .alu_result_m(alu_result_m), .writedata_m(writedata_m), .flush_w(flush_w),
        .busy_m(busy_m), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w),
        .rd_w(rd_w), .pcplus4_w(pcplus4_w), .alu_result_w(alu_result_w),
        .readdata_w(readdata_w), .trap_w(trap_w)
    );

    mem_lane_align #(.XLEN(32)) u_ref (
        .funct3(la_f3), .offset(la_off), .is_store(la_st), .wdata_in(la_wd),
        .rdata_in(la_rd), .wdata_out(la_wo), .be(la_be), .rdata_out(la_ro),
        .misaligned(la_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_req && dmem_we && dmem_ack) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= dmem_addr;
            wr_data <= dmem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        rd_en, wr_en, regw;
        logic [4:0]  rd;
        logic [31:0] alu, wdata, rdata;
        int          delay;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_rdw;
        logic        exp_regw, exp_trap;
    } vec_t;

    function automatic vec_t mk(string name, logic [2:0] f3, logic rd_en, logic wr_en,
                                logic regw, logic [4:0] rd, logic [31:0] alu,
                                logic [31:0] wdata, logic [31:0] rdata, int delay,
                                logic exp_req, logic [31:0] exp_addr, logic [3:0] exp_be,
                                logic [31:0] exp_wdata, logic [31:0] exp_rdw,
                                logic exp_regw, logic exp_trap);
        vec_t v;
        v.name = name; v.f3 = f3; v.rd_en = rd_en; v.wr_en = wr_en; v.regw = regw;
        v.rd = rd; v.alu = alu; v.wdata = wdata; v.rdata = rdata; v.delay = delay;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.exp_rdw = exp_rdw; v.exp_regw = exp_regw;
        v.exp_trap = exp_trap;
        return v;
    endfunction

    task automatic idle_inputs();
        valid_m = 0; regwrite_m = 0; memread_m = 0; memwrite_m = 0; resultsrc_m = 0;
        funct3_m = 0; rd_m = 0; pcplus4_m = 0; alu_result_m = 0; writedata_m = 0;
        flush_w = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after the W-capture edge.
    task automatic run_vec(input vec_t v);
        valid_m = 1; regwrite_m = v.regw; memread_m = v.rd_en; memwrite_m = v.wr_en;
        resultsrc_m = v.rd_en; funct3_m = v.f3; rd_m = v.rd; pcplus4_m = 32'h0000_0444;
        alu_result_m = v.alu; writedata_m = v.wdata; dmem_rdata = v.rdata;
        dmem_ack = (v.delay == 0) && v.exp_req;
        #1;
        check({v.name, ".req"}, 32'(dmem_req), 32'(v.exp_req));
        if (v.exp_req) begin
            check({v.name, ".addr"}, dmem_addr, v.exp_addr);
            check({v.name, ".be"}, 32'(dmem_be), 32'(v.exp_be));
            check({v.name, ".we"}, 32'(dmem_we), 32'(v.wr_en));
            if (v.wr_en) check({v.name, ".wdata"}, dmem_wdata, v.exp_wdata);
        end
        check({v.name, ".busy0"}, 32'(busy_m), 32'(v.exp_req && v.delay > 0));
        for (int c = 1; c <= v.delay; c++) begin
            @(posedge clk); #1;
            check({v.name, ".bubble"}, 32'(regwrite_w), 32'd0);
            if (c == v.delay) dmem_ack = 1;
            #1;
            check({v.name, ".busy"}, 32'(busy_m), 32'(c < v.delay));
        end
        @(posedge clk); #1;
        check({v.name, ".regwrite_w"}, 32'(regwrite_w), 32'(v.exp_regw));
        check({v.name, ".readdata_w"}, readdata_w, v.exp_rdw);
        check({v.name, ".trap_w"}, 32'(trap_w), 32'(v.exp_trap));
        check({v.name, ".alu_w"}, alu_result_w, v.alu);
        check({v.name, ".rd_w"}, 32'(rd_w), 32'(v.rd));
        idle_inputs();
    endtask

    vec_t vecs[$];
    int   n0;

    initial begin
        vecs.push_back(mk("sw", F3_W, 0, 1, 0, 0, 32'h100, 32'hDEADBEEF, 0, 0,
                          1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk("lb_wait3", F3_B, 1, 0, 1, 5, 32'h103, 0, 32'h80FF_FF00, 3,
                          1, 32'h100, 4'hF, 0, 32'hFFFF_FF80, 1, 0));
        vecs.push_back(mk("lbu_wait3", F3_BU, 1, 0, 1, 6, 32'h103, 0, 32'h80FF_FF00, 3,
                          1, 32'h100, 4'hF, 0, 32'h0000_0080, 1, 0));
        vecs.push_back(mk("sh", F3_H, 0, 1, 0, 0, 32'h102, 32'h0000_1234, 0, 0,
                          1, 32'h100, 4'b1100, 32'h1234_1234, 0, 0, 0));
        vecs.push_back(mk("sb", F3_B, 0, 1, 0, 0, 32'h101, 32'h0000_00AB, 0, 1,
                          1, 32'h100, 4'b0010, 32'hABAB_ABAB, 0, 0, 0));
        vecs.push_back(mk("lh", F3_H, 1, 0, 1, 7, 32'h102, 0, 32'h8001_7FFF, 1,
                          1, 32'h100, 4'hF, 0, 32'hFFFF_8001, 1, 0));
        vecs.push_back(mk("lhu", F3_HU, 1, 0, 1, 8, 32'h100, 0, 32'h1234_F00D, 0,
                          1, 32'h100, 4'hF, 0, 32'h0000_F00D, 1, 0));
        vecs.push_back(mk("lw", F3_W, 1, 0, 1, 9, 32'h104, 0, 32'hCAFE_BABE, 2,
                          1, 32'h104, 4'hF, 0, 32'hCAFE_BABE, 1, 0));
        vecs.push_back(mk("ld_as_w", F3_D, 1, 0, 1, 10, 32'h108, 0, 32'h8765_4321, 0,
                          1, 32'h108, 4'hF, 0, 32'h8765_4321, 1, 0));
        vecs.push_back(mk("lb_pos", F3_B, 1, 0, 1, 11, 32'h100, 0, 32'h0000_007F, 0,
                          1, 32'h100, 4'hF, 0, 32'h0000_007F, 1, 0));
        vecs.push_back(mk("alu_op", F3_B, 0, 0, 1, 12, 32'h55, 0, 0, 0,
                          0, 0, 0, 0, 0, 1, 0));
`ifdef MEM_MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_mis", F3_W, 1, 0, 1, 13, 32'h101, 0, 32'h0BAD_F00D, 0,
                          0, 0, 0, 0, 0, 0, 1));
`else
        vecs.push_back(mk("lw_mis", F3_W, 1, 0, 1, 13, 32'h101, 0, 32'h0BAD_F00D, 0,
                          1, 32'h100, 4'hF, 0, 32'h0BAD_F00D, 1, 0));
`endif

        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.req", 32'(dmem_req), 0);
        check("reset.regwrite_w", 32'(regwrite_w), 0);
        check("reset.readdata_w", readdata_w, 0);
        rst = 0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Standalone lane-align reference checks.
        la_f3 = F3_H; la_off = 2; la_st = 0; la_wd = 0; la_rd = 32'h8001_0000;
        #1 check("lane.lh", la_ro, 32'hFFFF_8001);
        la_f3 = F3_B; la_off = 3; la_st = 1; la_wd = 32'h0000_005A;
        #1 check("lane.sb_wd", la_wo, 32'h5A5A_5A5A);
        check("lane.sb_be", 32'(la_be), 32'h8);
        la_f3 = F3_HU; la_off = 1; la_st = 0; la_rd = 32'h0000_9876;
        #1 check("lane.lhu_mis", la_ro, 32'h0000_9876);
        check("lane.mis", 32'(la_mis), 1);

        // Async reset clears a live W register.
        @(posedge clk); #1;
        valid_m = 1; regwrite_m = 1; rd_m = 3; alu_result_m = 32'h77; pcplus4_m = 32'h88;
        @(posedge clk); #1;
        check("wlive.alu_w", alu_result_w, 32'h77);
        rst = 1; #1;
        check("wrst.alu_w", alu_result_w, 0);
        check("wrst.pc4_w", pcplus4_w, 0);
        check("wrst.regwrite_w", 32'(regwrite_w), 0);
        rst = 0; idle_inputs();
        @(posedge clk); #1;

        // Reset in WAIT abandons the access.
        valid_m = 1; memread_m = 1; regwrite_m = 1; funct3_m = F3_W; alu_result_m = 32'h140;
        rd_m = 4; #1;
        check("wait.req", 32'(dmem_req), 1);
        repeat (2) @(posedge clk);
        #2 rst = 1; #1;
        check("rstwait.req", 32'(dmem_req), 0);
        check("rstwait.rd_w", 32'(rd_w), 0);
        check("rstwait.readdata_w", readdata_w, 0);
        idle_inputs(); #1 rst = 0;
        @(posedge clk); #1;
        check("rstwait.idle_req", 32'(dmem_req), 0);
        run_vec(vecs[0]);

        // Flush with same-cycle ack: store still lands, W sees a bubble.
        valid_m = 1; memwrite_m = 1; funct3_m = F3_W; alu_result_m = 32'h200;
        writedata_m = 32'h1122_3344; flush_w = 1; dmem_ack = 1; #1;
        check("flush_sw.we", 32'(dmem_we), 1);
        n0 = wr_cnt;
        @(posedge clk); #1;
        check("flush_sw.wr_cnt", 32'(wr_cnt), 32'(n0 + 1));
        check("flush_sw.wr_data", wr_data, 32'h1122_3344);
        check("flush_sw.alu_w", alu_result_w, 0);
        memwrite_m = 0; memread_m = 1; regwrite_m = 1; rd_m = 9; alu_result_m = 32'h204;
        dmem_rdata = 32'h77;
        @(posedge clk); #1;
        check("flush_lw.regwrite_w", 32'(regwrite_w), 0);
        check("flush_lw.readdata_w", readdata_w, 0);
        idle_inputs();
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
